// File: rtl/disp_pkg.sv
// Shared types and constants for the display pixel buffer.
package disp_pkg;

  localparam int BURST_BEATS    = 8;
  localparam int DEPTH_LOG2_DEF = 9;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam pixel_t BLACK = '{r: 8'h00, g: 8'h00, b: 8'h00};

endpackage

// File: rtl/disp_fifo_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port, no array reset.
module disp_fifo_ram
  import disp_pkg::*;
#(
  parameter int ADDR_W = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [23:0]       wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [23:0]       rdata
);

  pixel_t mem_q [0:(1<<ADDR_W)-1];
  pixel_t rdata_q;

  // Write port and registered read port; rdata holds while re is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/disp_buffer_sc.sv
// Pixel FIFO between the VRAM read path (AXI R beats) and the display output stage.
module disp_buffer_sc
  import disp_pkg::*;
#(
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF,
  parameter int WREADY_FREE = 16
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic [31:0] RDATA,
  input  logic        RVALID,
  input  logic        RLAST,
  output logic        RREADY,
  input  logic        DISPON,
  input  logic        VRSTART,
  input  logic        RD_EN,
  output logic        BUF_WREADY,
  output logic [7:0]  DSP_R,
  output logic [7:0]  DSP_G,
  output logic [7:0]  DSP_B,
  output logic        DSP_DE,
  output logic        BUF_UNDER
);

  localparam int AW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          under_q, under_d;
  logic          de_q, de_d;
  logic          sel_ram_q, sel_ram_d;
  pixel_t        last_q, last_d;

  logic          full_s, empty_s, rready_s, push_s, pop_s, underflow_s, flush_s;
  logic [CW-1:0] free_s;
  logic [23:0]   ram_rdata_s;
  pixel_t        dsp_pix_s;
  logic          unused_s;

  assign unused_s    = &{1'b0, RLAST, RDATA[31:24]};
  assign full_s      = (count_q == CW'(DEPTH));
  assign empty_s     = (count_q == {CW{1'b0}});
  assign free_s      = CW'(DEPTH) - count_q;
  assign rready_s    = ARST & DISPON & ~full_s & ~VRSTART;
  assign push_s      = RVALID & rready_s;
  assign pop_s       = RD_EN & ~empty_s & DISPON;
  assign underflow_s = RD_EN & empty_s & DISPON;
  assign flush_s     = VRSTART | ~DISPON;

  // Shown pixel is either the fresh RAM word or the held/black value.
  assign dsp_pix_s = sel_ram_q ? pixel_t'(ram_rdata_s) : last_q;

  disp_fifo_ram #(.ADDR_W(AW)) u_ram (
    .clk   (ACLK),
    .we    (push_s),
    .waddr (wptr_q),
    .wdata (RDATA[23:0]),
    .re    (pop_s),
    .raddr (rptr_q),
    .rdata (ram_rdata_s)
  );

  // Next-state for pointers, occupancy, sticky underflow and output select.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    under_d   = under_q;
    de_d      = RD_EN & DISPON;
    sel_ram_d = 1'b0;
    last_d    = dsp_pix_s;

    if (flush_s) begin
      wptr_d  = {AW{1'b0}};
      rptr_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wptr_d = wptr_q + AW'(1'b1);
      end else begin
        wptr_d = wptr_q;
      end
      if (pop_s) begin
        rptr_d = rptr_q + AW'(1'b1);
      end else begin
        rptr_d = rptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end

    if (VRSTART) begin
      under_d = 1'b0;
    end else if (underflow_s) begin
      under_d = 1'b1;
    end else begin
      under_d = under_q;
    end

    if (!DISPON) begin
      last_d    = BLACK;
      sel_ram_d = 1'b0;
    end else if (underflow_s) begin
      last_d    = BLACK;
      sel_ram_d = 1'b0;
    end else if (pop_s) begin
      last_d    = dsp_pix_s;
      sel_ram_d = 1'b1;
    end else begin
      last_d    = dsp_pix_s;
      sel_ram_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARST) begin
      wptr_q    <= {AW{1'b0}};
      rptr_q    <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      under_q   <= 1'b0;
      de_q      <= 1'b0;
      sel_ram_q <= 1'b0;
      last_q    <= BLACK;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      under_q   <= under_d;
      de_q      <= de_d;
      sel_ram_q <= sel_ram_d;
      last_q    <= last_d;
    end
  end

  assign RREADY     = rready_s;
  assign BUF_WREADY = DISPON & (free_s >= CW'(WREADY_FREE));
  assign DSP_R      = dsp_pix_s.r;
  assign DSP_G      = dsp_pix_s.g;
  assign DSP_B      = dsp_pix_s.b;
  assign DSP_DE     = de_q;
  assign BUF_UNDER  = under_q;

endmodule

// File: tb/tb_disp_buffer_sc.sv
// Randomized self-checking bench for disp_buffer_sc against a queue-based FIFO model.
module tb_disp_buffer_sc;

  logic        ACLK = 1'b0;
  logic        ARST, RVALID, RLAST, DISPON, VRSTART, RD_EN;
  logic [31:0] RDATA;
  logic        RREADY, BUF_WREADY, DSP_DE, BUF_UNDER;
  logic [7:0]  DSP_R, DSP_G, DSP_B;

  disp_buffer_sc dut (
    .ACLK(ACLK), .ARST(ARST), .RDATA(RDATA), .RVALID(RVALID), .RLAST(RLAST),
    .RREADY(RREADY), .DISPON(DISPON), .VRSTART(VRSTART), .RD_EN(RD_EN),
    .BUF_WREADY(BUF_WREADY), .DSP_R(DSP_R), .DSP_G(DSP_G), .DSP_B(DSP_B),
    .DSP_DE(DSP_DE), .BUF_UNDER(BUF_UNDER)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [23:0] mq[$];
  logic        m_under  = 1'b0;
  logic [23:0] exp_pix  = 24'h0;
  logic        exp_de   = 1'b0;
  logic        exp_rready, exp_wready, act_rready, act_wready;

  // One clock of stimulus; model advances from the FIFO rules, outputs sampled #1 after the edge.
  task automatic step(input logic rv, input logic [31:0] rd, input logic re,
                      input logic on, input logic vs);
    @(negedge ACLK);
    RVALID = rv; RDATA = rd; RD_EN = re; DISPON = on; VRSTART = vs;
    RLAST = 1'b0;
    #1;
    act_rready = RREADY;
    act_wready = BUF_WREADY;
    exp_rready = on && !vs && (mq.size() < 512);
    exp_wready = on && ((512 - mq.size()) >= 16);
    if (re && on) begin
      if (mq.size() > 0) exp_pix = mq.pop_front();
      else begin exp_pix = 24'h0; m_under = 1'b1; end
    end
    if (!on) exp_pix = 24'h0;
    exp_de = re && on;
    if (rv && exp_rready) mq.push_back(rd[23:0]);
    if (vs || !on) mq.delete();
    if (vs) m_under = 1'b0;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_reset();
    ARST = 1'b0; DISPON = 1'b1; VRSTART = 1'b0; RVALID = 1'b0; RD_EN = 1'b1;
    RDATA = 32'h0; RLAST = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    n_checks++;
    if ({DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER} !== 26'h0)
      $display("FAIL reset_out: de/rgb/under got %b/%h%h%h/%b want 0/000000/0",
               DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER);
    else n_pass++;
    @(negedge ACLK);
    ARST = 1'b1; RD_EN = 1'b0;
    mq.delete(); m_under = 1'b0; exp_pix = 24'h0; exp_de = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({act_rready, act_wready, DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER} !== 28'hC000000)
      $display("FAIL reset_idle: rready/wready/de/rgb/under got %b/%b/%b/%h%h%h/%b want 1/1/0/000000/0",
               act_rready, act_wready, DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER);
    else n_pass++;
  endtask

  task automatic test_burst();
    for (int i = 0; i < 8; i++) step(1'b1, 32'h00112233 + i, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER} !== {1'b1, 24'h112233 + 24'(i), 1'b0})
        $display("FAIL burst[%0d]: de/rgb/under got %b/%h%h%h/%b want 1/%h/0",
                 i, DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER, 24'h112233 + 24'(i));
      else n_pass++;
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (DSP_DE !== 1'b0 || {DSP_R, DSP_G, DSP_B} !== 24'h11223A)
      $display("FAIL burst_hold: de/rgb got %b/%h%h%h want 0/11223a", DSP_DE, DSP_R, DSP_G, DSP_B);
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [31:0] d;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 512; i++) begin
      d = $urandom;
      step(1'b1, d, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (act_wready !== exp_wready || act_rready !== 1'b1 || (i == 497 && act_wready !== 1'b0)
          || (i == 496 && act_wready !== 1'b1))
        $display("FAIL fill[%0d]: wready/rready got %b/%b want %b/1", i, act_wready, act_rready, exp_wready);
      else n_pass++;
    end
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (act_rready !== 1'b0 || DSP_DE !== 1'b1 || {DSP_R, DSP_G, DSP_B} !== exp_pix)
      $display("FAIL full_pop: rready/de/rgb got %b/%b/%h%h%h want 0/1/%h",
               act_rready, DSP_DE, DSP_R, DSP_G, DSP_B, exp_pix);
    else n_pass++;
    step(1'b1, 32'h00ABCDEF, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (act_rready !== 1'b1) $display("FAIL full_reenable: rready got %b want 1", act_rready);
    else n_pass++;
    for (int i = 0; i < 512; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER} !== {exp_de, exp_pix, m_under})
        $display("FAIL drain[%0d]: de/rgb/under got %b/%h%h%h/%b want %b/%h/%b",
                 i, DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER, exp_de, exp_pix, m_under);
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER} !== {1'b1, 24'h0, 1'b1})
      $display("FAIL under_black: de/rgb/under got %b/%h%h%h/%b want 1/000000/1",
               DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER);
    else n_pass++;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (BUF_UNDER !== 1'b1) $display("FAIL under_sticky: under got %b want 1", BUF_UNDER);
    else n_pass++;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (BUF_UNDER !== 1'b0 || BUF_WREADY !== 1'b1)
      $display("FAIL under_clear: under/wready got %b/%b want 0/1", BUF_UNDER, BUF_WREADY);
    else n_pass++;
    step(1'b1, 32'h00A1B2C3, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER} !== {1'b1, 24'hA1B2C3, 1'b1})
      $display("FAIL empty_push_pop: de/rgb/under got %b/%h%h%h/%b want 1/a1b2c3/1",
               DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER);
    else n_pass++;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_vrstart();
    for (int i = 0; i < 100; i++) step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h00FFEEDD, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (act_rready !== 1'b0) $display("FAIL vrstart_rready: rready got %b want 0", act_rready);
    else n_pass++;
    step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER} !== {1'b1, 24'h0, 1'b1})
      $display("FAIL vrstart_flush: de/rgb/under got %b/%h%h%h/%b want 1/000000/1",
               DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER);
    else n_pass++;
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 511; i++) step(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'h00C0DE00 + i, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (act_rready !== 1'b1 || act_wready !== 1'b0 || mq.size() != 511
          || {DSP_DE, DSP_R, DSP_G, DSP_B} !== {1'b1, exp_pix})
        $display("FAIL wrap[%0d]: rready/wready/de/rgb got %b/%b/%b/%h%h%h want 1/0/1/%h",
                 i, act_rready, act_wready, DSP_DE, DSP_R, DSP_G, DSP_B, exp_pix);
      else n_pass++;
    end
    for (int i = 0; i < 512; i++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if ({DSP_DE, DSP_R, DSP_G, DSP_B} !== {exp_de, exp_pix})
        $display("FAIL wrap_drain[%0d]: de/rgb got %b/%h%h%h want %b/%h",
                 i, DSP_DE, DSP_R, DSP_G, DSP_B, exp_de, exp_pix);
      else n_pass++;
    end
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_random();
    logic rv, re, on, vs;
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom_range(99) < 60);
      re = ($urandom_range(99) < 55);
      on = ($urandom_range(199) != 0);
      vs = ($urandom_range(299) == 0);
      step(rv, $urandom, re, on, vs);
      n_checks++;
      if ({act_rready, act_wready, DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER}
          !== {exp_rready, exp_wready, exp_de, exp_pix, m_under})
        $display("FAIL random[%0d]: rr/wr/de/rgb/under got %b/%b/%b/%h%h%h/%b want %b/%b/%b/%h/%b",
                 i, act_rready, act_wready, DSP_DE, DSP_R, DSP_G, DSP_B, BUF_UNDER,
                 exp_rready, exp_wready, exp_de, exp_pix, m_under);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_fill();
    test_underflow();
    test_vrstart();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_buffer_sc.md
# disp_buffer_sc

Single-clock pixel buffer between the VRAM read controller and the display output stage. It accepts 32-bit read-data beats from the AXI R channel into a 512-entry FIFO. It raises BUF_WREADY whenever there is room for another 8-beat burst. It pops one pixel per cycle on the sync generator's read request and drives registered RGB and DE.

## Interface
- DEPTH_LOG2, 9: FIFO depth is 2^DEPTH_LOG2 words (512).
- WREADY_FREE, 16: minimum free entries for BUF_WREADY; must be ≥ 2 × BURST_BEATS.
- ACLK  in  1  clock. One clock; reset is synchronous and active-low.
- ARST  in  1  synchronous reset, active-low (asserted when 0).
- RDATA  in  32  AXI read data; [23:16]=R, [15:8]=G, [7:0]=B, [31:24] ignored.
- RVALID  in  1  AXI read data valid.
- RLAST  in  1  AXI last beat. Informational only; not used for storage.
- RREADY  out  1  AXI read data ready.
- DISPON  in  1  display enable.
- VRSTART  in  1  frame-start pulse; flushes the FIFO.
- RD_EN  in  1  pixel request from syncgen, one pixel per cycle.
- BUF_WREADY  out  1  room for at least one more burst.
- DSP_R, DSP_G, DSP_B  out  8 each  pixel output.
- DSP_DE  out  1  output data enable.
- BUF_UNDER  out  1  sticky underflow flag.

## Operation
- State:
  - wptr and rptr, DEPTH_LOG2 bits each; both wrap modulo DEPTH.
  - count, DEPTH_LOG2+1 bits, range 0..DEPTH.
  - full = (count == DEPTH). empty = (count == 0). Both come from the registered count only.
- RREADY = DISPON & !full & !VRSTART.
- push = RVALID & RREADY. On a push, RDATA[23:0] is written at wptr, then wptr+1.
- BUF_WREADY = DISPON & ((DEPTH − count) ≥ WREADY_FREE). It is combinational from registered count.
- pop = RD_EN & !empty & DISPON. On a pop, the RAM reads at rptr, then rptr+1.
- count update: +1 on push only, −1 on pop only, unchanged when both occur or neither occurs.
- Underflow: RD_EN & empty & DISPON sets BUF_UNDER. That cycle's output pixel is black (0,0,0) with DSP_DE=1.
- BUF_UNDER clears only on reset or VRSTART.
- Flush: when VRSTART=1 or DISPON=0, wptr, rptr and count go to 0 next edge.
  - Flush wins over any simultaneous push or pop; both are discarded.
  - During DISPON=0, DSP_DE=0 and RGB=0.
- No fall-through: a word pushed in cycle n is poppable from cycle n+1.

## Timing
- Reset (ARST=0 at an edge) sets: pointers=0, count=0, DSP_R/G/B=0, DSP_DE=0, BUF_UNDER=0.
  - Consequent combinational outputs: RREADY=0 while DISPON=0; BUF_WREADY follows DISPON.
- Reset mid-burst: the FIFO empties and remaining R beats see RREADY=0 until DISPON is high and reset is released. The upstream controller is reset by the same signal.
- Read latency: RD_EN sampled at edge n gives DSP_* and DSP_DE valid after edge n+1.
  - DSP_DE(n+1) = RD_EN(n) & DISPON(n).
  - RGB comes from the RAM synchronous read, or is black on underflow.
  - RGB holds its last value when DSP_DE=0.
- Full boundary: at count=DEPTH, RREADY=0. A simultaneous pop does not enable a push in the same cycle; the push proceeds next cycle.
- Empty boundary: a push and RD_EN in the same cycle at count=0 is an underflow. The pushed word is kept and count becomes 1.
- Burst margin: BUF_WREADY is sampled by the controller at RLAST.
  - WREADY_FREE ≥ 16 guarantees an already-issued burst, up to 8 beats in flight, never meets RREADY=0 due to full under normal throttling.
  - Full back-pressure remains legal AXI behaviour.

## Structure
- Package disp_pkg holds:
  - BURST_BEATS = 8.
  - DEPTH_LOG2 default.
  - typedef pixel_t = 24-bit packed struct {r, g, b}.
  - BLACK constant.
- Sub-module disp_fifo_ram: simple dual-port RAM, 2^DEPTH_LOG2 × 24.
  - One write port (we, waddr, wdata) and a registered read port (re, raddr, rdata).
  - No reset on the array.
- Top holds pointers, count, flag logic and the output register stage.

## Test plan
- Reset release with DISPON=1, no traffic -> RREADY=1, BUF_WREADY=1, DSP_DE=0, RGB=0, BUF_UNDER=0.
- Push 8 beats with RDATA=0x00112233+i, then RD_EN for 8 cycles -> DSP_DE high for 8 cycles starting one cycle after the first RD_EN, RGB = (0x11,0x22,0x33+i) in order. BUF_UNDER stays 0.
- Fill without pops -> BUF_WREADY falls when count reaches 497, RREADY falls at count 512. One pop re-enables RREADY in the next cycle.
- RD_EN on an empty FIFO -> black pixel with DSP_DE=1, BUF_UNDER=1 and sticky. The next VRSTART clears it and leaves count=0.
- VRSTART pulse coincident with RVALID at count=100 -> RREADY=0 that cycle, count=0 next cycle, and the beat is not stored.
- Simultaneous push and pop at count=511 across wptr wrap (511→0) -> count stays 511, and data order is preserved across the wrap.
